// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential multiplier among NREQ requesters.
// Optional WAIT-state timeout is enabled by defining MULT_TIMEOUT_EN; the default build has no timeout.
module mult_arbiter #(
    parameter int DW      = 9,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [2*DW-1:0]      rsp_product,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mult_start,
    output logic [DW-1:0]        mult_multiplicand,
    output logic [DW-1:0]        mult_multipliers,
    input  logic                 mult_ready,
    input  logic [2*DW-1:0]      mult_product
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d, owner_q, owner_d, win, idx;
    logic [IW:0]       sum;
    logic              found;
    logic [NREQ-1:0]   ack_q, ack_d, rv_q, rv_d;
    logic [DW-1:0]     a_q, a_d, b_q, b_d;
    logic [2*DW-1:0]   prod_q, prod_d;
    logic              start_q, start_d, busy_q, busy_d;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick: scanning downward leaves the nearest valid requester after last_q as the winner
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = (IW + 1)'(last_q) + (IW + 1)'(k);
            idx = IW'(sum >= (IW + 1)'(NREQ) ? sum - (IW + 1)'(NREQ) : sum);
            if (req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Sequencer next state plus the next value of every registered output
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
`ifdef MULT_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    owner_d = win;
                    a_d     = req_a[win*DW +: DW];
                    b_d     = req_b[win*DW +: DW];
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mult_ready) begin
                    state_d = DONE;
                    prod_d  = mult_product;
`ifdef MULT_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    prod_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
        endcase
        ack_d   = (state_q == IDLE && found) ? NREQ'(1) << win : '0;
        rv_d    = (state_q == WAIT && state_d == DONE) ? NREQ'(1) << owner_q : '0;
        start_d = state_d == ISSUE;
        busy_d  = state_d != IDLE;
    end

    // State and output registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            start_q <= start_d;
            busy_q  <= busy_d;
`ifdef MULT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ack           = ack_q;
    assign rsp_valid         = rv_q;
    assign rsp_product       = prod_q;
    assign busy              = busy_q;
    assign mult_start        = start_q;
    assign mult_multiplicand = a_q;
    assign mult_multipliers  = b_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural multiplier and round-robin reference.
module tb_mult_arbiter;
    localparam int DW   = 9;
    localparam int NREQ = 4;
    localparam int PW   = 2 * DW;
`ifdef MULT_TIMEOUT_EN
    localparam int TO   = 8;
`else
    localparam int TO   = 64;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_a = '0;
    logic [NREQ*DW-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ack, rsp_valid;
    logic [PW-1:0]        rsp_product;
    logic                 rsp_err, busy, mult_start;
    logic [DW-1:0]        mult_multiplicand, mult_multipliers;
    logic                 mult_ready = 1'b0;
    logic [PW-1:0]        mult_product = '0;

    typedef struct {int owner; logic [PW-1:0] prod; logic err;} exp_t;
    typedef struct {logic [DW-1:0] a; logic [DW-1:0] b;} op_t;

    exp_t          sb[$];
    exp_t          m_e;
    op_t           pend[NREQ][$];
    op_t           d_o;
    int            grants[$];
    int            vec = 0, mis = 0;
    int            last = NREQ - 1;
    logic [PW-1:0] last_rsp = '0;
    bit            rand_en = 0, mute = 0, spur = 0, exp_to = 0;
    int            m_cnt = -1;
    logic [DW-1:0] m_a = '0, m_b = '0;
    bit            d_free = 1, d_pf = 0, d_prdy = 0;
    int            d_w;
    logic [NREQ-1:0] d_exp;
    logic [DW-1:0] ca = '0, cb = '0;
    int            n;

    always #5 clk = ~clk;

    mult_arbiter #(.DW(DW), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
        .rsp_err(rsp_err), .busy(busy), .mult_start(mult_start),
        .mult_multiplicand(mult_multiplicand), .mult_multipliers(mult_multipliers),
        .mult_ready(mult_ready), .mult_product(mult_product)
    );

    function automatic void chk(string nm, longint act, longint exp);
        vec++;
        if (act != exp) begin
            mis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int rr_pick(int l, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    function automatic int pend_cnt();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += pend[i].size();
        return s;
    endfunction

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || req_valid != 0 || pend_cnt() != 0 || busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            vec++;
            mis++;
            $display("FAIL drain: timed out with %0d responses outstanding", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Behavioural multiplier: random 0..5 extra WAIT cycles, optional injected stray ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_cnt = -1;
                mult_ready = 1'b0;
            end else begin
                mult_ready = 1'b0;
                if (m_cnt == 0) begin
                    mult_ready = 1'b1;
                    mult_product = PW'(m_a) * PW'(m_b);
                    m_cnt = -1;
                end else if (m_cnt > 0) m_cnt--;
                if (spur) begin
                    mult_ready = 1'b1;
                    mult_product = PW'(18'h2AAAA);
                end
                if (mult_start && !mute) begin
                    m_a = mult_multiplicand;
                    m_b = mult_multipliers;
                    m_cnt = int'($urandom_range(0, 5));
                end
            end
        end
    end

    // Requesters plus round-robin reference: predicts each ack and queues the expected response
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                req_valid = '0;
                d_free = 1;
                d_pf = 0;
                d_prdy = 0;
            end else begin
                d_w = d_free ? rr_pick(last, req_valid) : -1;
                d_exp = (d_w >= 0) ? NREQ'(1) << d_w : '0;
                chk("req_ack", longint'(req_ack), longint'(d_exp));
                chk("mult_start", longint'(mult_start), longint'(d_w >= 0));
                if (d_w >= 0) begin
                    grants.push_back(d_w);
                    ca = req_a[d_w*DW +: DW];
                    cb = req_b[d_w*DW +: DW];
                    sb.push_back('{d_w, exp_to ? PW'(0) : PW'(ca) * PW'(cb), exp_to});
                    req_valid[d_w] = 1'b0;
                    d_free = 0;
                end
                if (!d_free) begin
                    chk("operand_a", longint'(mult_multiplicand), longint'(ca));
                    chk("operand_b", longint'(mult_multipliers), longint'(cb));
                end
                if (rsp_valid != 0 && !exp_to) chk("ready_to_rsp", longint'(d_prdy), 1);
                if (d_pf) begin
                    d_free = 1;
                    d_pf = 0;
                end
                if (rsp_valid != 0) d_pf = 1;
                d_prdy = mult_ready;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && rand_en && $urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end else if (!req_valid[i] && (pend[i].size() > 0 || (rand_en && $urandom_range(0, 3) == 0))) begin
                        if (pend[i].size() > 0) d_o = pend[i].pop_front();
                        else d_o = '{DW'($urandom_range(0, 511)), DW'($urandom_range(0, 511))};
                        req_a[i*DW +: DW] = d_o.a;
                        req_b[i*DW +: DW] = d_o.b;
                        req_valid[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response strobe appears
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                last = NREQ - 1;
            end else if (rsp_valid != 0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", longint'(rsp_valid), 0);
                end else begin
                    m_e = sb.pop_front();
                    chk("rsp_valid", longint'(rsp_valid), longint'(1) << m_e.owner);
                    chk("rsp_product", longint'(rsp_product), longint'(m_e.prod));
                    chk("rsp_err", longint'(rsp_err), longint'(m_e.err));
                    last = m_e.owner;
                    last_rsp = rsp_product;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ack", longint'(req_ack), 0);
        chk("rst_rsp_valid", longint'(rsp_valid), 0);
        chk("rst_start", longint'(mult_start), 0);
        chk("rst_err", longint'(rsp_err), 0);
        chk("rst_product", longint'(rsp_product), 0);
        chk("rst_op_a", longint'(mult_multiplicand), 0);
        chk("rst_op_b", longint'(mult_multipliers), 0);
        @(posedge clk);
        #3 rst = 1'b1;

        grants.delete();
        for (int i = 0; i < NREQ; i++) pend[i].push_back('{DW'(85), DW'(85)});
        pend[0].push_back('{DW'(85), DW'(85)});
        drain();
        chk("rr_count", grants.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < grants.size()) chk("rr_order", grants[k], k % NREQ);
        chk("rr_product", longint'(last_rsp), 7225);

        pend[0].push_back('{DW'(85), DW'(127)});
        drain();
        chk("single_product", longint'(last_rsp), 10795);

        pend[2].push_back('{DW'(511), DW'(511)});
        drain();
        chk("max_product", longint'(last_rsp), 261121);

        mute = 1;
        pend[0].push_back('{DW'(7), DW'(9)});
        n = 0;
        while (!mult_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_start_seen", longint'(mult_start), 1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_reset_busy", longint'(busy), 0);
        chk("mid_reset_ack", longint'(req_ack), 0);
        chk("mid_reset_rsp_valid", longint'(rsp_valid), 0);
        chk("mid_reset_start", longint'(mult_start), 0);
        chk("mid_reset_product", longint'(rsp_product), 0);
        chk("mid_reset_op_a", longint'(mult_multiplicand), 0);
        chk("mid_reset_op_b", longint'(mult_multipliers), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        mute = 0;
        @(negedge clk) spur = 1;
        @(negedge clk) spur = 0;
        repeat (2) @(negedge clk);
        pend[1].push_back('{DW'(3), DW'(5)});
        drain();
        chk("after_reset_product", longint'(last_rsp), 15);

        @(negedge clk) pend[2].push_back('{DW'(100), DW'(200)});
        @(negedge clk) spur = 1;
        @(negedge clk) spur = 0;
        drain();
        chk("spurious_ready_product", longint'(last_rsp), 20000);

`ifdef MULT_TIMEOUT_EN
        mute = 1;
        exp_to = 1;
        @(negedge clk) pend[3].push_back('{DW'(12), DW'(34)});
        n = 0;
        while (req_ack == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (rsp_valid == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, 9);
        @(negedge clk);
        exp_to = 0;
        mute = 0;
        pend[0].push_back('{DW'(2), DW'(3)});
        drain();
        chk("after_timeout_product", longint'(last_rsp), 6);
`endif

        rand_en = 1;
        repeat (3000) @(posedge clk);
        rand_en = 0;
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
